bcd_stopwatch: RTL and testbench

- Consumes the divided clock level from the clock-divider stage and counts in MM:SS format: 4 BCD digits, minutes 00-99, seconds 00-59.
- Runs entirely in the clk100Mhz domain; the slow clock is never used as a clock.
- Counts up or down from a preset, with start/stop and clear controls.
- Digit outputs feed the seven-segment display stage.

---
 rtl/bcd_stopwatch.sv | 206 ++++++++++++++++++++
 tb/tb_bcd_stopwatch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch
//   MM:SS stopwatch with four BCD digits (minutes 00-99, seconds 00-59).
//   Counts one second per rising edge of tick_in, a slow clock level from the
//   divider. tick_in is only sampled as data in the clk100Mhz domain and is
//   never used as a clock. Counts up or down from a clamped preset, with
//   start/stop and clear controls.
//
// Parameters
//   SYNC_STAGES : synchronizer depth on tick_in (2..4)
//   ROLL_OVER   : up-mode behaviour at 99:59 (0 = stop in DONE, 1 = wrap)
//
// Ports
//   clk100Mhz  in   system clock
//   reset_n    in   asynchronous active-low reset
//   tick_in    in   slow clock level, one count per rising edge
//   start_stop in   one-cycle pulse, toggles run/pause
//   clear      in   one-cycle pulse, back to IDLE and load preset
//   dir        in   0 = up, 1 = down (latched on IDLE->RUN)
//   preset     in   BCD {M1,M0,S1,S0}, clamped when loaded
//   digits     out  current count, BCD {M1,M0,S1,S0}
//   running    out  high in RUN
//   done       out  high in DONE
// ---------------------------------------------------------------------------
module bcd_stopwatch #(
  parameter int SYNC_STAGES = 2,
  parameter bit ROLL_OVER   = 1'b0
) (
  input  logic        clk100Mhz,
  input  logic        reset_n,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        dir,
  input  logic [15:0] preset,
  output logic [15:0] digits,
  output logic        running,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] MAX_COUNT = 16'h9959;

  // One second forward. 99:59 wraps to 00:00; the caller decides whether
  // that wrap is allowed.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (s0 != 4'd9) begin
      s0 = s0 + 4'd1;
    end else begin
      s0 = 4'd0;
      if (s1 != 4'd5) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        if (m0 != 4'd9) begin
          m0 = m0 + 4'd1;
        end else begin
          m0 = 4'd0;
          m1 = (m1 == 4'd9) ? 4'd0 : m1 + 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  // One second backward. Never called with 00:00 while running down, since
  // reaching 00:00 moves the FSM to DONE.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = (m1 == 4'd0) ? 4'd0 : m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  // Non-BCD digits saturate to 9, then the tens-of-seconds digit to 5.
  function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (m1 > 4'd9) m1 = 4'd9;
    if (m0 > 4'd9) m0 = 4'd9;
    if (s0 > 4'd9) s0 = 4'd9;
    if (s1 > 4'd5) s1 = 4'd5;
    return {m1, m0, s1, s0};
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   tick_ev;
  state_t                 state_q, state_d;
  logic [15:0]            digits_q, digits_d;
  logic                   dir_q, dir_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;
  logic [15:0]            dec_val;

  // Synchronizer chain and edge detector on the slow clock level
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], tick_in};
    dly_d   = sync_q[SYNC_STAGES-1];
    tick_ev = sync_q[SYNC_STAGES-1] & ~dly_q;
  end

  always_ff @(posedge clk100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  // Next-state, count and flag logic
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    dir_d    = dir_q;
    dec_val  = bcd_dec(digits_q);

    if (clear) begin
      state_d  = ST_IDLE;
      digits_d = bcd_clamp(preset);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_stop) begin
            dir_d   = dir;
            state_d = (dir && digits_q == 16'h0000) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          // A start_stop on a tick edge still counts that tick; a terminal
          // count below overrides the pause with DONE.
          if (start_stop) state_d = ST_PAUSE;
          if (tick_ev) begin
            if (!dir_q) begin
              if (digits_q == MAX_COUNT) begin
                if (ROLL_OVER) digits_d = 16'h0000;
                else           state_d  = ST_DONE;
              end else begin
                digits_d = bcd_inc(digits_q);
              end
            end else begin
              digits_d = dec_val;
              if (dec_val == 16'h0000) state_d = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          // Resuming does not count a tick arriving on the same edge.
          if (start_stop) state_d = ST_RUN;
        end
        ST_DONE: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      digits_q  <= 16'h0000;
      dir_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign digits  = digits_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
module tb_bcd_stopwatch;

  logic        clk100Mhz = 1'b0;
  logic        reset_n;
  logic        tick_in;
  logic        start_stop;
  logic        clear;
  logic        dir;
  logic [15:0] preset;
  logic [15:0] digits0, digits1;
  logic        running0, running1, done0, done1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk100Mhz = ~clk100Mhz;

  bcd_stopwatch #(.SYNC_STAGES(2), .ROLL_OVER(1'b0)) u_stop (
    .clk100Mhz(clk100Mhz), .reset_n(reset_n), .tick_in(tick_in),
    .start_stop(start_stop), .clear(clear), .dir(dir), .preset(preset),
    .digits(digits0), .running(running0), .done(done0)
  );

  bcd_stopwatch #(.SYNC_STAGES(2), .ROLL_OVER(1'b1)) u_wrap (
    .clk100Mhz(clk100Mhz), .reset_n(reset_n), .tick_in(tick_in),
    .start_stop(start_stop), .clear(clear), .dir(dir), .preset(preset),
    .digits(digits1), .running(running1), .done(done1)
  );

  // Advance n clock edges; inputs are driven and outputs sampled 1 ns after.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk100Mhz);
      #1;
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
  endtask

  task automatic load(input logic [15:0] p);
    preset = p;
    clear  = 1'b1;
    cyc(1);
    clear  = 1'b0;
  endtask

  // One full tick_in period: count lands on the 3rd edge after the rise.
  task automatic tick();
    tick_in = 1'b1;
    cyc(3);
    tick_in = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0;
    dir = 1'b0; preset = 16'h0000;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    n_checks++; if (digits0 !== 16'h0000) begin n_fail++; $display("FAIL reset_digits got %h want 0000", digits0); end
    n_checks++; if (running0 !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done0); end
    repeat (3) tick();
    n_checks++; if (digits0 !== 16'h0000) begin n_fail++; $display("FAIL idle_ignores_ticks got %h want 0000", digits0); end
    n_checks++; if (running0 !== 1'b0) begin n_fail++; $display("FAIL idle_running got %b want 0", running0); end
  endtask

  task automatic test_up_count();
    logic [15:0] exp_seq [3];
    logic [15:0] prev;
    exp_seq = '{16'h0059, 16'h0100, 16'h0101};
    dir = 1'b0;
    load(16'h0058);
    n_checks++; if (digits0 !== 16'h0058) begin n_fail++; $display("FAIL up_load got %h want 0058", digits0); end
    pulse_ss();
    n_checks++; if (running0 !== 1'b1) begin n_fail++; $display("FAIL up_running got %b want 1", running0); end
    prev = 16'h0058;
    for (int i = 0; i < 3; i++) begin
      tick_in = 1'b1;
      cyc(2);
      n_checks++; if (digits0 !== prev) begin n_fail++; $display("FAIL up_early[%0d] got %h want %h", i, digits0, prev); end
      cyc(1);
      n_checks++; if (digits0 !== exp_seq[i]) begin n_fail++; $display("FAIL up_step[%0d] got %h want %h", i, digits0, exp_seq[i]); end
      tick_in = 1'b0;
      cyc(4);
      n_checks++; if (digits0 !== exp_seq[i]) begin n_fail++; $display("FAIL up_no_fall_count[%0d] got %h want %h", i, digits0, exp_seq[i]); end
      prev = exp_seq[i];
    end
  endtask

  task automatic test_up_saturate();
    dir = 1'b0;
    load(16'h9958);
    pulse_ss();
    tick();
    n_checks++; if (digits0 !== 16'h9959) begin n_fail++; $display("FAIL sat_first got %h want 9959", digits0); end
    n_checks++; if (running0 !== 1'b1) begin n_fail++; $display("FAIL sat_first_running got %b want 1", running0); end
    tick();
    n_checks++; if (digits0 !== 16'h9959) begin n_fail++; $display("FAIL sat_hold got %h want 9959", digits0); end
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL sat_done got %b want 1", done0); end
    n_checks++; if (running0 !== 1'b0) begin n_fail++; $display("FAIL sat_running got %b want 0", running0); end
    n_checks++; if (digits1 !== 16'h0000) begin n_fail++; $display("FAIL wrap_digits got %h want 0000", digits1); end
    n_checks++; if (running1 !== 1'b1) begin n_fail++; $display("FAIL wrap_running got %b want 1", running1); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL wrap_done got %b want 0", done1); end
    tick();
    n_checks++; if (digits0 !== 16'h9959) begin n_fail++; $display("FAIL sat_extra got %h want 9959", digits0); end
    n_checks++; if (digits1 !== 16'h0001) begin n_fail++; $display("FAIL wrap_extra got %h want 0001", digits1); end
    pulse_ss();
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL done_ignores_ss got %b want 1", done0); end
  endtask

  task automatic test_down();
    dir = 1'b1;
    load(16'h1000);
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL clear_done got %b want 0", done0); end
    pulse_ss();
    dir = 1'b0;
    tick();
    n_checks++; if (digits0 !== 16'h0959) begin n_fail++; $display("FAIL down_borrow got %h want 0959", digits0); end
    n_checks++; if (running0 !== 1'b1) begin n_fail++; $display("FAIL down_running got %b want 1", running0); end
    dir = 1'b1;
    load(16'h0002);
    pulse_ss();
    tick();
    n_checks++; if (digits0 !== 16'h0001) begin n_fail++; $display("FAIL down_one got %h want 0001", digits0); end
    tick();
    n_checks++; if (digits0 !== 16'h0000) begin n_fail++; $display("FAIL down_zero got %h want 0000", digits0); end
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL down_done got %b want 1", done0); end
    n_checks++; if (running0 !== 1'b0) begin n_fail++; $display("FAIL down_done_running got %b want 0", running0); end
    tick();
    n_checks++; if (digits0 !== 16'h0000) begin n_fail++; $display("FAIL down_no_wrap got %h want 0000", digits0); end
    load(16'h0000);
    pulse_ss();
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL zero_start_done got %b want 1", done0); end
    n_checks++; if (running0 !== 1'b0) begin n_fail++; $display("FAIL zero_start_running got %b want 0", running0); end
    dir = 1'b0;
  endtask

  task automatic test_collision();
    dir = 1'b0;
    load(16'h0005);
    pulse_ss();
    // start_stop lands on the edge where tick_ev is applied
    tick_in = 1'b1;
    cyc(2);
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
    n_checks++; if (digits0 !== 16'h0006) begin n_fail++; $display("FAIL pause_counted got %h want 0006", digits0); end
    n_checks++; if (running0 !== 1'b0) begin n_fail++; $display("FAIL pause_running got %b want 0", running0); end
    tick_in = 1'b0;
    cyc(4);
    repeat (5) tick();
    n_checks++; if (digits0 !== 16'h0006) begin n_fail++; $display("FAIL pause_hold got %h want 0006", digits0); end
    tick_in = 1'b1;
    cyc(2);
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
    n_checks++; if (running0 !== 1'b1) begin n_fail++; $display("FAIL resume_running got %b want 1", running0); end
    n_checks++; if (digits0 !== 16'h0006) begin n_fail++; $display("FAIL resume_not_counted got %h want 0006", digits0); end
    tick_in = 1'b0;
    cyc(4);
    tick();
    n_checks++; if (digits0 !== 16'h0007) begin n_fail++; $display("FAIL resume_counts got %h want 0007", digits0); end
  endtask

  task automatic test_clear_priority();
    // Running from the previous test; clear, start_stop and tick_ev together
    tick_in = 1'b1;
    cyc(2);
    preset = 16'hA7C3;
    clear = 1'b1;
    start_stop = 1'b1;
    cyc(1);
    clear = 1'b0;
    start_stop = 1'b0;
    n_checks++; if (digits0 !== 16'h9753) begin n_fail++; $display("FAIL clear_clamp got %h want 9753", digits0); end
    n_checks++; if (running0 !== 1'b0) begin n_fail++; $display("FAIL clear_running got %b want 0", running0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL clear_prio_done got %b want 0", done0); end
    tick_in = 1'b0;
    cyc(4);
    tick();
    n_checks++; if (digits0 !== 16'h9753) begin n_fail++; $display("FAIL clear_idle_hold got %h want 9753", digits0); end
    pulse_ss();
    tick();
    n_checks++; if (digits0 !== 16'h9754) begin n_fail++; $display("FAIL clamp_run got %h want 9754", digits0); end
    // Reset between clock edges must act without waiting for an edge
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (digits0 !== 16'h0000) begin n_fail++; $display("FAIL async_reset_digits got %h want 0000", digits0); end
    n_checks++; if (running0 !== 1'b0) begin n_fail++; $display("FAIL async_reset_running got %b want 0", running0); end
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_up_saturate();
    test_down();
    test_collision();
    test_clear_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "timeout");
  end

endmodule
